// File: rtl/brick_collision_pkg.sv
// Shared definitions for the brick collision stage: FSM states, brick wall and
// paddle geometry defaults, and a clamped-subtract helper.
package brick_collision_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PADDLE,
    ST_REPORT
  } state_e;

  localparam int unsigned DEF_BRICK_COLS = 8;
  localparam int unsigned DEF_BRICK_ROWS = 4;
  localparam int unsigned DEF_BRICK_W    = 80;
  localparam int unsigned DEF_BRICK_H    = 16;
  localparam int unsigned DEF_BRICK_TOP  = 48;

  localparam int unsigned DEF_PADDLE_Y   = 440;
  localparam int unsigned DEF_PADDLE_H   = 8;
  localparam int unsigned DEF_PADDLE_W   = 64;
  localparam int unsigned DEF_BALL_R     = 8;

  // a - b, floored at zero so the ball's left/top extent never wraps
  function automatic logic [10:0] sub_clamp(input logic [10:0] a, input logic [10:0] b);
    return (a < b) ? '0 : a - b;
  endfunction

endpackage

// File: rtl/brick_collision_geom.sv
// Maps a brick index to its screen rectangle and tests it against the ball's
// bounding box; also reports whether the ball centre lies within the brick's columns.
module brick_geom
  import brick_collision_pkg::*;
#(
  parameter int unsigned BRICK_COLS = DEF_BRICK_COLS,
  parameter int unsigned BRICK_W    = DEF_BRICK_W,
  parameter int unsigned BRICK_H    = DEF_BRICK_H,
  parameter int unsigned BRICK_TOP  = DEF_BRICK_TOP,
  parameter int unsigned BALL_R     = DEF_BALL_R
) (
  input  logic [5:0] idx,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       overlap,
  output logic       x_inside
);

  logic [10:0] idx_w, row, col;
  logic [10:0] bx0, bx1, by0, by1;
  logic [10:0] cx, cy, xl, xh, yl, yh;

  always_comb begin
    idx_w    = {5'd0, idx};
    row      = idx_w / 11'(BRICK_COLS);
    col      = idx_w % 11'(BRICK_COLS);
    bx0      = col * 11'(BRICK_W);
    by0      = 11'(BRICK_TOP) + row * 11'(BRICK_H);
    bx1      = bx0 + 11'(BRICK_W - 1);
    by1      = by0 + 11'(BRICK_H - 1);
    cx       = {1'b0, ball_x};
    cy       = {1'b0, ball_y};
    xl       = sub_clamp(cx, 11'(BALL_R));
    xh       = cx + 11'(BALL_R);
    yl       = sub_clamp(cy, 11'(BALL_R));
    yh       = cy + 11'(BALL_R);
    overlap  = (xh >= bx0) && (xl <= bx1) && (yh >= by0) && (yl <= by1);
    x_inside = (cx >= bx0) && (cx <= bx1);
  end

endmodule

// File: rtl/brick_collision.sv
// Per-frame collision stage: snapshots ball/paddle on vsync fall, scans the brick
// wall one brick per cycle, runs the paddle test, then pulses h/v collision once.
module brick_collision
  import brick_collision_pkg::*;
#(
  parameter int unsigned BRICK_COLS = DEF_BRICK_COLS,
  parameter int unsigned BRICK_ROWS = DEF_BRICK_ROWS,
  parameter int unsigned BRICK_W    = DEF_BRICK_W,
  parameter int unsigned BRICK_H    = DEF_BRICK_H,
  parameter int unsigned BRICK_TOP  = DEF_BRICK_TOP,
  parameter int unsigned PADDLE_Y   = DEF_PADDLE_Y,
  parameter int unsigned PADDLE_H   = DEF_PADDLE_H,
  parameter int unsigned PADDLE_W   = DEF_PADDLE_W,
  parameter int unsigned BALL_R     = DEF_BALL_R
) (
  input  logic                               pxl_clk,
  input  logic                               reset,
  input  logic                               vsync,
  input  logic [9:0]                         ball_x,
  input  logic [9:0]                         ball_y,
  input  logic [9:0]                         paddle_x,
  input  logic                               new_game,
  output logic                               h_collision,
  output logic                               v_collision,
  output logic [BRICK_COLS*BRICK_ROWS-1:0]   brick_map,
  output logic [5:0]                         bricks_left,
  output logic [7:0]                         score,
  output logic                               all_clear,
  output logic                               busy
);

  localparam int unsigned N = BRICK_COLS * BRICK_ROWS;

  state_e       state_q, state_d;
  logic         vsync_d_q;
  logic [9:0]   x_q, x_d, y_q, y_d, px_q, px_d;
  logic [5:0]   idx_q, idx_d;
  logic         hit_q, hit_d, h_q, h_d, v_q, v_d;
  logic         pad_q, pad_d, guard_q, guard_d;
  logic [N-1:0] map_q, map_d, sel;
  logic [5:0]   left_q, left_d;
  logic [7:0]   score_q, score_d;
  logic         clear_q, clear_d;
  logic         trigger, overlap, x_inside, pad_hit;
  logic [10:0]  pxl, pxh, pyh, pxr;

  brick_geom #(
    .BRICK_COLS (BRICK_COLS),
    .BRICK_W    (BRICK_W),
    .BRICK_H    (BRICK_H),
    .BRICK_TOP  (BRICK_TOP),
    .BALL_R     (BALL_R)
  ) u_geom (
    .idx      (idx_q),
    .ball_x   (x_q),
    .ball_y   (y_q),
    .overlap  (overlap),
    .x_inside (x_inside)
  );

  always_comb begin
    pyh     = {1'b0, y_q} + 11'(BALL_R);
    pxh     = {1'b0, x_q} + 11'(BALL_R);
    pxl     = sub_clamp({1'b0, x_q}, 11'(BALL_R));
    pxr     = {1'b0, px_q} + 11'(PADDLE_W - 1);
    pad_hit = (pyh >= 11'(PADDLE_Y)) && (pyh <= 11'(PADDLE_Y + PADDLE_H)) &&
              (pxh >= {1'b0, px_q}) && (pxl <= pxr);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    px_d    = px_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    h_d     = h_q;
    v_d     = v_q;
    pad_d   = pad_q;
    guard_d = guard_q;
    map_d   = map_q;
    left_d  = left_q;
    score_d = score_q;
    trigger = vsync_d_q & ~vsync;
    sel     = N'(1) << idx_q;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          x_d     = ball_x;
          y_d     = ball_y;
          px_d    = paddle_x;
          idx_d   = '0;
          hit_d   = 1'b0;
          h_d     = 1'b0;
          v_d     = 1'b0;
          pad_d   = 1'b0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // only the lowest-index present brick counts; hit_q masks the rest
        if (!hit_q && |(map_q & sel) && overlap) begin
          map_d  = map_q & ~sel;
          left_d = left_q - 6'd1;
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          hit_d  = 1'b1;
          if (x_inside) v_d = 1'b1;
          else          h_d = 1'b1;
        end
        if (idx_q == 6'(N - 1)) state_d = ST_PADDLE;
        else                    idx_d   = idx_q + 6'd1;
      end
      ST_PADDLE: begin
        pad_d   = pad_hit & ~guard_q;
        guard_d = pad_hit;
        state_d = ST_REPORT;
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (new_game) begin
      state_d = ST_IDLE;
      h_d     = 1'b0;
      v_d     = 1'b0;
      pad_d   = 1'b0;
      guard_d = 1'b0;
      map_d   = '1;
      left_d  = 6'(N);
      score_d = '0;
    end
    clear_d = (left_d == '0);
  end

  always_ff @(posedge pxl_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      vsync_d_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      px_q      <= '0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      h_q       <= 1'b0;
      v_q       <= 1'b0;
      pad_q     <= 1'b0;
      guard_q   <= 1'b0;
      map_q     <= '1;
      left_q    <= 6'(N);
      score_q   <= '0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      vsync_d_q <= vsync;
      x_q       <= x_d;
      y_q       <= y_d;
      px_q      <= px_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      h_q       <= h_d;
      v_q       <= v_d;
      pad_q     <= pad_d;
      guard_q   <= guard_d;
      map_q     <= map_d;
      left_q    <= left_d;
      score_q   <= score_d;
      clear_q   <= clear_d;
    end
  end

  assign h_collision = (state_q == ST_REPORT) && h_q;
  assign v_collision = (state_q == ST_REPORT) && (v_q || pad_q);
  assign brick_map   = map_q;
  assign bricks_left = left_q;
  assign score       = score_q;
  assign all_clear   = clear_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
